// File: rtl/sobel_window_sequencer_if.sv
// Handshake and memory bus bundle between the Sobel window sequencer,
// its image memory and the downstream Sobel core.
interface sobel_window_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 3
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    mem_rd_en;
    logic [ADDR_W-1:0]       mem_row;
    logic [ADDR_W-1:0]       mem_col;
    logic [DATA_WIDTH-1:0]   mem_rd_data;
    logic [9*DATA_WIDTH-1:0] win_flat;
    logic [ADDR_W-1:0]       win_row;
    logic [ADDR_W-1:0]       win_col;
    logic                    win_valid;
    logic                    win_ready;

    modport master (
        input  start, mem_rd_data, win_ready,
        output busy, done, mem_rd_en, mem_row, mem_col,
        output win_flat, win_row, win_col, win_valid
    );

    modport slave (
        output start, mem_rd_data, win_ready,
        input  busy, done, mem_rd_en, mem_row, mem_col,
        input  win_flat, win_row, win_col, win_valid
    );
endinterface

// File: rtl/sobel_window_sequencer.sv
// Walks interior pixels in raster order, fetching 3x3 windows from a
// single-port synchronous memory and presenting them via valid/ready.
module sobel_window_sequencer #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 3
) (
    input logic clk,
    input logic rst,
    sobel_window_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_FULL,
        S_FETCH_COL,
        S_DRAIN,
        S_PRESENT,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_WIDTH - 2);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_HEIGHT - 2);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_e                      state_q, state_d;
    logic [ADDR_W-1:0]           row_q, row_d;
    logic [ADDR_W-1:0]           col_q, col_d;
    logic [1:0]                  ii_q, ii_d;
    logic [1:0]                  jj_q, jj_d;
    logic                        rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]           mem_row_q, mem_row_d;
    logic [ADDR_W-1:0]           mem_col_q, mem_col_d;
    logic                        cap_v_q, cap_v_d;
    logic [1:0]                  cap_i_q, cap_i_d;
    logic [1:0]                  cap_j_q, cap_j_d;
    logic [3:0]                  cap_idx;
    logic [8:0][DATA_WIDTH-1:0]  win_q, win_d;
    logic                        valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [ADDR_W-1:0]           wrow_q, wrow_d;
    logic [ADDR_W-1:0]           wcol_q, wcol_d;

    // ii/jj name the window element fetched by the read issued this cycle
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        ii_d    = ii_q;
        jj_d    = jj_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH_FULL;
                    row_d   = ONE;
                    col_d   = ONE;
                    ii_d    = 2'd0;
                    jj_d    = 2'd0;
                end
            end
            S_FETCH_FULL: begin
                if (ii_q == 2'd2) begin
                    ii_d = 2'd0;
                    if (jj_q == 2'd2) begin
                        state_d = S_DRAIN;
                    end else begin
                        jj_d = jj_q + 2'd1;
                    end
                end else begin
                    ii_d = ii_q + 2'd1;
                end
            end
            S_FETCH_COL: begin
                if (ii_q == 2'd2) begin
                    ii_d    = 2'd0;
                    state_d = S_DRAIN;
                end else begin
                    ii_d = ii_q + 2'd1;
                end
            end
            S_DRAIN: state_d = S_PRESENT;
            S_PRESENT: begin
                if (bus.win_ready) begin
                    ii_d = 2'd0;
                    if (col_q < COL_LAST) begin
                        col_d   = col_q + ONE;
                        jj_d    = 2'd2;
                        state_d = S_FETCH_COL;
                    end else if (row_q < ROW_LAST) begin
                        row_d   = row_q + ONE;
                        col_d   = ONE;
                        jj_d    = 2'd0;
                        state_d = S_FETCH_FULL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cap_idx = 4'(cap_i_q) * 4'd3 + 4'(cap_j_q);

    // Outputs are computed from the next state so they leave flops
    always_comb begin
        rd_en_d   = (state_d == S_FETCH_FULL) || (state_d == S_FETCH_COL);
        mem_row_d = rd_en_d ? row_d + ADDR_W'(ii_d) - ONE : '0;
        mem_col_d = rd_en_d ? col_d + ADDR_W'(jj_d) - ONE : '0;
        valid_d   = (state_d == S_PRESENT);
        wrow_d    = valid_d ? row_d : '0;
        wcol_d    = valid_d ? col_d : '0;
        busy_d    = state_d inside {S_FETCH_FULL, S_FETCH_COL,
                                    S_DRAIN, S_PRESENT};
        done_d    = (state_d == S_DONE);
        cap_v_d   = rd_en_q;
        cap_i_d   = ii_q;
        cap_j_d   = jj_q;
        win_d     = win_q;
        if (state_q == S_PRESENT && state_d == S_FETCH_COL) begin
            for (int i = 0; i < 3; i++) begin
                win_d[3*i]   = win_q[3*i+1];
                win_d[3*i+1] = win_q[3*i+2];
            end
        end
        if (cap_v_q) begin
            win_d[cap_idx] = bus.mem_rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= ONE;
            col_q     <= ONE;
            ii_q      <= 2'd0;
            jj_q      <= 2'd0;
            rd_en_q   <= 1'b0;
            mem_row_q <= '0;
            mem_col_q <= '0;
            cap_v_q   <= 1'b0;
            cap_i_q   <= 2'd0;
            cap_j_q   <= 2'd0;
            win_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrow_q    <= '0;
            wcol_q    <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ii_q      <= ii_d;
            jj_q      <= jj_d;
            rd_en_q   <= rd_en_d;
            mem_row_q <= mem_row_d;
            mem_col_q <= mem_col_d;
            cap_v_q   <= cap_v_d;
            cap_i_q   <= cap_i_d;
            cap_j_q   <= cap_j_d;
            win_q     <= win_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrow_q    <= wrow_d;
            wcol_q    <= wcol_d;
        end
    end

    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_row   = mem_row_q;
    assign bus.mem_col   = mem_col_q;
    assign bus.win_flat  = win_q;
    assign bus.win_valid = valid_q;
    assign bus.win_row   = wrow_q;
    assign bus.win_col   = wcol_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Scoreboard bench for sobel_window_sequencer: frame-level model of
// expected reads, windows and cycle timing, compared by a monitor.
module tb_sobel_window_sequencer;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NWIN = (W - 2) * (H - 2);
    localparam int NRD  = 9 * (H - 2) + 3 * (W - 3) * (H - 2);

    typedef struct packed {
        logic [AW-1:0]   r;
        logic [AW-1:0]   c;
        logic [9*DW-1:0] f;
    } win_t;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [AW-1:0] c;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [DW-1:0] img [H][W];
    win_t wq[$];
    rd_t  rq[$];

    logic active = 1'b0;
    logic frame_done = 1'b0;
    logic prev_valid = 1'b0;
    logic need_rd = 1'b0;
    int   start_cyc = 0;
    int   last_hs = 0;
    int   gap = 11;
    int   hs_cnt = 0;
    int   rd_cnt = 0;
    int   exp_done_cyc = 0;

    int   rdy_mode = 0;
    logic noise_en = 1'b0;
    logic rdy = 1'b0;
    logic stalled = 1'b0;
    int   stall_left = 0;
    logic start_main = 1'b0;
    logic start_noise = 1'b0;

    sobel_window_sequencer_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    sobel_window_sequencer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_WIDTH(DW),
        .ADDR_W    (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.win_ready = rdy;
    assign bus.start     = start_main | start_noise;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= img[bus.mem_row][bus.mem_col];
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Consumer and start-noise driver
    always @(posedge clk) begin
        #1;
        if (rdy_mode != 2) stalled = 1'b0;
        if (rdy_mode == 1) begin
            rdy = ($urandom_range(0, 2) != 0);
        end else if (rdy_mode == 2 && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
        end else if (rdy_mode == 2 && !stalled && bus.win_valid &&
                     bus.win_row == AW'(3) && bus.win_col == AW'(4)) begin
            rdy = 1'b0;
            stalled = 1'b1;
            stall_left = 6;
        end else begin
            rdy = 1'b1;
        end
        start_noise = noise_en && bus.busy && ($urandom_range(0, 1) == 1);
    end

    win_t mw;
    rd_t  me;
    int   rel;
    logic exp_done;

    always @(negedge clk) begin
        if (!rst && active) begin
            rel = cyc - start_cyc;
            exp_done = (wq.size() == 0) && (rel == last_hs + 1);
            chk("done", 128'(bus.done), 128'(exp_done));
            chk("busy", 128'(bus.busy), 128'((rel >= 1) && !exp_done));
            if (bus.mem_rd_en) begin
                rd_cnt++;
                if (need_rd) begin
                    chk("first_read_cycle", 128'(rel), 128'(last_hs + 1));
                    need_rd = 1'b0;
                end
                if (rq.size() == 0) begin
                    chk("read_count", 128'(rd_cnt), 128'(NRD));
                end else begin
                    me = rq.pop_front();
                    chk("read_addr", 128'({bus.mem_row, bus.mem_col}),
                        128'({me.r, me.c}));
                end
            end
            if (bus.win_valid) begin
                chk("read_during_valid", 128'(bus.mem_rd_en), 128'(0));
                if (!prev_valid)
                    chk("valid_rise_cycle", 128'(rel), 128'(last_hs + gap));
                if (wq.size() == 0) begin
                    chk("window_count", 128'(hs_cnt + 1), 128'(NWIN));
                end else begin
                    mw = wq[0];
                    chk("window",
                        128'({bus.win_row, bus.win_col, bus.win_flat}),
                        128'({mw.r, mw.c, mw.f}));
                    if (bus.win_ready) begin
                        void'(wq.pop_front());
                        hs_cnt++;
                        last_hs = rel;
                        gap = (mw.c < AW'(W - 2)) ? 5 : 11;
                        need_rd = (wq.size() > 0);
                    end
                end
            end
            prev_valid = bus.win_valid;
            if (bus.done) begin
                chk("windows_total", 128'(hs_cnt), 128'(NWIN));
                chk("reads_total", 128'(rd_cnt), 128'(NRD));
                if (exp_done_cyc > 0)
                    chk("done_cycle", 128'(rel), 128'(exp_done_cyc));
                active = 1'b0;
                frame_done = 1'b1;
            end
        end else if (!rst) begin
            chk("idle_done", 128'(bus.done), 128'(0));
            chk("idle_busy", 128'(bus.busy), 128'(0));
            chk("idle_read", 128'(bus.mem_rd_en), 128'(0));
            chk("idle_valid", 128'(bus.win_valid), 128'(0));
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
        chk({tag, "_done"}, 128'(bus.done), 128'(0));
        chk({tag, "_rd_en"}, 128'(bus.mem_rd_en), 128'(0));
        chk({tag, "_mem_addr"}, 128'({bus.mem_row, bus.mem_col}), 128'(0));
        chk({tag, "_valid"}, 128'(bus.win_valid), 128'(0));
        chk({tag, "_win_pos"}, 128'({bus.win_row, bus.win_col}), 128'(0));
        chk({tag, "_win_flat"}, 128'(bus.win_flat), 128'(0));
    endtask

    task automatic build_queues(input int pat);
        win_t w;
        rd_t  e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (pat == 0) ? DW'(8 * r + c) : DW'($urandom);
        wq.delete();
        rq.delete();
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                w.r = AW'(r);
                w.c = AW'(c);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        w.f[(3*i+j)*DW +: DW] = img[r-1+i][c-1+j];
                wq.push_back(w);
                if (c == 1) begin
                    for (int j = 0; j < 3; j++)
                        for (int i = 0; i < 3; i++) begin
                            e.r = AW'(r - 1 + i);
                            e.c = AW'(c - 1 + j);
                            rq.push_back(e);
                        end
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        e.r = AW'(r - 1 + i);
                        e.c = AW'(c + 1);
                        rq.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic begin_frame(input int pat, input int mode, input int edc);
        build_queues(pat);
        rdy_mode = mode;
        exp_done_cyc = edc;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        last_hs = 0;
        gap = 11;
        hs_cnt = 0;
        rd_cnt = 0;
        prev_valid = 1'b0;
        need_rd = 1'b1;
        frame_done = 1'b0;
        active = 1'b1;
        start_main = 1'b1;
        @(posedge clk);
        #1;
        start_main = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!frame_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_finished", 128'(frame_done), 128'(1));
        if (!frame_done) active = 1'b0;
    endtask

    task automatic run_frame(input int pat, input int mode,
                             input logic noise, input int edc);
        begin_frame(pat, mode, edc);
        noise_en = noise;
        wait_done();
        noise_en = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic abort_frame();
        int n = 0;
        begin_frame(0, 0, 0);
        while (hs_cnt < 8 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached", 128'(hs_cnt), 128'(8));
        @(posedge clk);
        #2;
        active = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero("abort");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        run_frame(0, 0, 1'b0, 217);
        run_frame(1, 1, 1'b1, 0);
        run_frame(1, 2, 1'b0, 224);
        abort_frame();
        run_frame(0, 0, 1'b0, 217);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sobel_window_sequencer.md
# sobel_window_sequencer

Sequences the Sobel datapath over one image frame. It walks every interior pixel in raster order and fetches 3x3 neighbourhoods from a single-port synchronous image memory, one read per cycle. It reuses two window columns when stepping along a row, so only the new right-hand column is read. Each completed window is presented to the Sobel core and its consumer through a valid/ready handshake.

## Interface
- IMG_WIDTH, 8, frame width in pixels (≥3)
- IMG_HEIGHT, 8, frame height in pixels (≥3)
- DATA_WIDTH, 8, pixel width
- ADDR_W, 3, row/column coordinate width; must hold IMG_WIDTH-1 and IMG_HEIGHT-1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final window handshake
- mem_rd_en  out  1  memory read strobe
- mem_row  out  ADDR_W  read row address
- mem_col  out  ADDR_W  read column address
- mem_rd_data  in  DATA_WIDTH  read data, valid in the cycle after mem_rd_en
- win_flat  out  9*DATA_WIDTH  window; element (i,j) at bits [(3*i+j)*DATA_WIDTH +: DATA_WIDTH], with i the row offset and j the column offset
- win_row  out  ADDR_W  centre row of the presented window
- win_col  out  ADDR_W  centre column of the presented window
- win_valid  out  1  window and coordinates valid
- win_ready  in  1  consumer accepts the window

## Operation
- States:
  - IDLE
  - FETCH_FULL: 9 reads
  - FETCH_COL: 3 reads
  - DRAIN: capture the last read's data
  - PRESENT: win_valid=1
  - DONE
- IDLE transitions:
  - start=1 → set row=1, col=1, go to FETCH_FULL.
  - Otherwise stay in IDLE.
- FETCH_FULL order: columns col-1, col, col+1; within each column, rows row-1, row, row+1. Data fills window[i][j] in that order.
- FETCH_COL order: column col+1, rows row-1, row, row+1. Data fills window[i][2].
- Window shift: on entry to FETCH_COL, window[i][0]←window[i][1] and window[i][1]←window[i][2] for all i.
- DRAIN captures the final datum, then goes to PRESENT.
- PRESENT:
  - Holds until win_valid&&win_ready.
  - On handshake, if col<IMG_WIDTH-2: col+1, go to FETCH_COL.
  - Else if row<IMG_HEIGHT-2: col=1, row+1, go to FETCH_FULL.
  - Else go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- mem_rd_en is high only during FETCH_* read cycles. Each read's data is captured at the end of the following cycle.
- Addresses are always in range; no border padding is needed because only interior pixels are visited.
- start outside IDLE is ignored. win_ready outside PRESENT is ignored.
- Window contents are unsigned and passed through unmodified; the gradient is computed downstream.

## Timing
- Reset values: all outputs are 0, window registers are 0, state is IDLE, row=col=1.
- rst mid-frame aborts immediately with no done pulse. The next start restarts from (1,1).
- Let cycle 0 be the cycle in which start is accepted:
  - Reads occur in cycles 1–9.
  - win_valid is first high in cycle 11.
- Let H be a handshake cycle:
  - Column step: reads in H+1..H+3, win_valid high in H+5.
  - Row step: reads in H+1..H+9, win_valid high in H+11.
- While win_valid=1 && win_ready=0, win_flat, win_row and win_col are stable.
- win_valid drops in the cycle after the handshake.
- With win_ready tied high on an 8x8 frame:
  - 36 windows are presented.
  - The last win_valid is in cycle 216.
  - done pulses in cycle 217; busy falls in the same cycle.
- Throughput: one window per 5 cycles within a row; 11-cycle gap at a row change.

## Test plan
- Memory model pixel=8*row+col, win_ready=1, pulse start → first window (1,1) in cycle 11 with p00..p22 = 0,1,2,8,9,10,16,17,18. Second window (1,2) = 1,2,3,9,10,11,17,18,19 in cycle 16.
- Same model, full frame → 36 windows in raster order (1,1)..(6,6). Window (6,6) = 45,46,47,53,54,55,61,62,63. done is a single pulse in cycle 217. Exactly 9*6 + 3*30 = 144 reads.
- win_ready held low 7 cycles at window (3,4) → win_valid and win_flat stable throughout, no reads issued, next reads start the cycle after ready rises.
- Row transition from (1,6) to (2,1) → 9 reads at column addresses 0,0,0,1,1,1,2,2,2. win_valid rises 11 cycles after the handshake.
- start reasserted during busy, and win_ready pulsed while win_valid=0 → no effect on sequence, counts or timing.
- rst asserted at window (2,3) mid-fetch → all outputs 0 asynchronously, no done. A later start yields window (1,1) again in cycle 11.
